// File: rtl/eve_child_collector.sv
// eve_child_collector: captures the three child genes of one bundle, drops all-zero genes and
// serializes the survivors into a first-word fall-through FIFO tagged with genome ID and last flag.
`default_nettype none

module eve_child_collector #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             input_clk,
  input  logic             reset,
  input  logic [7:0]       genomeID,
  input  logic             gene_valid,
  input  logic [63:0]      in_gene1,
  input  logic [63:0]      in_gene2,
  input  logic [63:0]      in_gene3,
  output logic             in_ready,
  output logic [63:0]      child_gene,
  output logic [7:0]       child_id,
  output logic             child_last,
  output logic             child_valid,
  input  logic             child_ready,
  output logic [CNT_W-1:0] gene_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 64 + 8 + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EMIT1 = 2'd1;
  localparam logic [1:0] EMIT2 = 2'd2;
  localparam logic [1:0] EMIT3 = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [2:0]    keep;
  logic [63:0]   gene1;
  logic [63:0]   gene2;
  logic [63:0]   gene3;
  logic [7:0]    id;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          capture;
  logic [2:0]    new_keep;
  logic [1:0]    drop_inc;
  logic [1:0]    first_state;
  logic          full;
  logic          push;
  logic          pop;
  logic [63:0]   wr_gene;
  logic          wr_last;
  logic [EW-1:0] wr_data;

  assign capture  = (state == IDLE) && gene_valid;
  assign new_keep = {|in_gene3, |in_gene2, |in_gene1};
  assign drop_inc = {1'b0, ~new_keep[0]} + {1'b0, ~new_keep[1]} + {1'b0, ~new_keep[2]};

  always_comb begin
    first_state = IDLE;
    if (new_keep[0])      first_state = EMIT1;
    else if (new_keep[1]) first_state = EMIT2;
    else if (new_keep[2]) first_state = EMIT3;
  end

  // last = no higher-numbered gene of this bundle is still to be emitted
  always_comb begin
    wr_gene    = gene3;
    wr_last    = 1'b1;
    state_next = IDLE;
    case (state)
      EMIT1: begin
        wr_gene    = gene1;
        wr_last    = ~(keep[1] | keep[2]);
        state_next = keep[1] ? EMIT2 : (keep[2] ? EMIT3 : IDLE);
      end
      EMIT2: begin
        wr_gene    = gene2;
        wr_last    = ~keep[2];
        state_next = keep[2] ? EMIT3 : IDLE;
      end
      default: begin
        wr_gene    = gene3;
        wr_last    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign wr_data = {wr_gene, id, wr_last};
  assign full    = (count == FULL_CNT);
  assign push    = (state != IDLE) && !full;
  assign pop     = (count != '0) && child_ready;

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      keep       <= '0;
      gene1      <= '0;
      gene2      <= '0;
      gene3      <= '0;
      id         <= '0;
      drop_count <= '0;
    end else if (capture) begin
      state      <= first_state;
      keep       <= new_keep;
      gene1      <= in_gene1;
      gene2      <= in_gene2;
      gene3      <= in_gene3;
      id         <= genomeID;
      drop_count <= drop_count + {{(CNT_W-2){1'b0}}, drop_inc};
    end else if (push) begin
      state      <= state_next;
    end
  end

  // Storage is cleared on reset so the head outputs read zero while held in reset.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      gene_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
        gene_count  <= gene_count + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign {child_gene, child_id, child_last} = mem[rd_ptr];
  assign child_valid = (count != '0);
  assign in_ready    = (state == IDLE) && reset;

endmodule

`default_nettype wire

// File: tb/tb_eve_child_collector.sv
// Scoreboard bench for eve_child_collector: stimulus pushes expected beats, a monitor pops and compares.
`timescale 1ns/1ps
`default_nettype none

module tb_eve_child_collector;

  logic        input_clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  genomeID = '0;
  logic        gene_valid = 1'b0;
  logic [63:0] in_gene1 = '0;
  logic [63:0] in_gene2 = '0;
  logic [63:0] in_gene3 = '0;
  logic        in_ready;
  logic [63:0] child_gene;
  logic [7:0]  child_id;
  logic        child_last;
  logic        child_valid;
  logic        child_ready = 1'b0;
  logic [15:0] gene_count;
  logic [15:0] drop_count;

  eve_child_collector #(.DEPTH(8), .CNT_W(16)) dut (
    .input_clk  (input_clk),
    .reset      (reset),
    .genomeID   (genomeID),
    .gene_valid (gene_valid),
    .in_gene1   (in_gene1),
    .in_gene2   (in_gene2),
    .in_gene3   (in_gene3),
    .in_ready   (in_ready),
    .child_gene (child_gene),
    .child_id   (child_id),
    .child_last (child_last),
    .child_valid(child_valid),
    .child_ready(child_ready),
    .gene_count (gene_count),
    .drop_count (drop_count)
  );

  always #5 input_clk = ~input_clk;

  logic [72:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_gc = 0;
  int          exp_dc = 0;
  logic        tog_on = 1'b0;
  logic        have_hold = 1'b0;
  logic [72:0] held = '0;

  task automatic check(input string nm, input logic [72:0] act, input logic [72:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every accepted beat and checks the head is stable while stalled
  always @(negedge input_clk) begin
    if (!reset) begin
      have_hold = 1'b0;
    end else begin
      if (have_hold) check("hold_stable", {child_gene, child_id, child_last}, held);
      if (child_valid && child_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got %0h expected none", {child_gene, child_id, child_last});
        end else begin
          check("beat", {child_gene, child_id, child_last}, sb.pop_front());
        end
      end
      have_hold = child_valid && !child_ready;
      held      = {child_gene, child_id, child_last};
    end
  end

  task automatic send(input logic [7:0] gid, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c);
    int t = 0;
    int kept = 0;
    while (!in_ready && t < 300) begin
      @(posedge input_clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 (id %0h)", gid);
      return;
    end
    genomeID = gid; in_gene1 = a; in_gene2 = b; in_gene3 = c; gene_valid = 1'b1;
    if (a != 0) begin sb.push_back({a, gid, (b == 0 && c == 0)}); kept++; end
    if (b != 0) begin sb.push_back({b, gid, (c == 0)}); kept++; end
    if (c != 0) begin sb.push_back({c, gid, 1'b1}); kept++; end
    exp_gc += kept;
    exp_dc += 3 - kept;
    @(posedge input_clk); #1;
    gene_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || child_valid || !in_ready) && t < 2000) begin
      @(posedge input_clk); #1;
      t++;
    end
    check("drain_left", 73'(sb.size()), 73'd0);
  endtask

  function automatic logic [63:0] gv(input logic [7:0] gid, input int k);
    return {gid, 48'h0000_C0DE_0000, 8'(k)};
  endfunction

  initial begin
    // 1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      gene_valid = 1'($urandom);
      genomeID   = 8'($urandom);
      in_gene1   = {$urandom, $urandom};
      in_gene2   = {$urandom, $urandom};
      in_gene3   = {$urandom, $urandom};
      child_ready = 1'($urandom);
      @(negedge input_clk);
      check("rst_in_ready", 73'(in_ready), 73'd0);
      check("rst_child_valid", 73'(child_valid), 73'd0);
      check("rst_gene_count", 73'(gene_count), 73'd0);
      check("rst_drop_count", 73'(drop_count), 73'd0);
    end
    gene_valid = 1'b0;
    child_ready = 1'b1;
    @(posedge input_clk); #1;
    reset = 1'b1;
    #1;
    check("release_in_ready", 73'(in_ready), 73'd1);

    // 2: full bundle
    send(8'h2A, gv(8'h2A, 1), gv(8'h2A, 2), gv(8'h2A, 3));
    drain();
    check("gc_full", 73'(gene_count), 73'(exp_gc));

    // 3: null filtering
    send(8'h31, gv(8'h31, 1), 64'd0, gv(8'h31, 3));
    drain();
    check("dc_gene2_null", 73'(drop_count), 73'(exp_dc));
    send(8'h32, 64'd0, 64'd0, 64'd0);
    @(negedge input_clk);
    check("all_null_ready", 73'(in_ready), 73'd1);
    check("all_null_valid", 73'(child_valid), 73'd0);
    check("dc_all_null", 73'(drop_count), 73'(exp_dc));
    send(8'h33, 64'd0, 64'd0, gv(8'h33, 3));
    drain();

    // 4: backpressure with three full bundles
    child_ready = 1'b0;
    for (int b = 0; b < 3; b++) send(8'h40 + 8'(b), gv(8'h40 + 8'(b), 1), gv(8'h40 + 8'(b), 2), gv(8'h40 + 8'(b), 3));
    repeat (8) @(posedge input_clk);
    #1;
    check("bp_in_ready", 73'(in_ready), 73'd0);
    check("bp_gene_count", 73'(gene_count), 73'(exp_gc - 1));
    check("bp_state_emit3", 73'(dut.state), 73'd3);
    child_ready = 1'b1;
    drain();
    check("bp_gc_after", 73'(gene_count), 73'(exp_gc));

    // 6: reset mid-stream during EMIT2 with 5 entries queued
    child_ready = 1'b0;
    send(8'h60, gv(8'h60, 1), gv(8'h60, 2), gv(8'h60, 3));
    send(8'h61, gv(8'h61, 1), 64'd0, 64'd0);
    send(8'h62, gv(8'h62, 1), gv(8'h62, 2), gv(8'h62, 3));
    @(posedge input_clk); #1;
    check("mid_occupancy", 73'(dut.count), 73'd5);
    reset = 1'b0;
    #1;
    check("mid_valid_async", 73'(child_valid), 73'd0);
    check("mid_in_ready", 73'(in_ready), 73'd0);
    sb.delete();
    exp_gc = 0;
    exp_dc = 0;
    @(posedge input_clk); #1;
    reset = 1'b1;
    child_ready = 1'b1;
    send(8'h70, gv(8'h70, 1), 64'd0, gv(8'h70, 3));
    drain();
    check("post_rst_gc", 73'(gene_count), 73'd2);
    check("post_rst_dc", 73'(drop_count), 73'd1);

    // 5: pointer wrap with toggling ready
    tog_on = 1'b1;
    fork
      begin
        while (tog_on) begin
          @(posedge input_clk); #1;
          child_ready = ~child_ready;
        end
      end
    join_none
    for (int b = 0; b < 20; b++) send(8'h80 + 8'(b), gv(8'h80 + 8'(b), 1), gv(8'h80 + 8'(b), 2), gv(8'h80 + 8'(b), 3));
    tog_on = 1'b0;
    repeat (3) @(posedge input_clk);
    #2;
    child_ready = 1'b1;
    drain();
    check("wrap_gc", 73'(gene_count), 73'(2 + 60));
    check("wrap_gc_model", 73'(gene_count), 73'(exp_gc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
